// File: rtl/phy_rx_lane.sv
// phy_rx_lane: one receive lane of the PHY.
// Deserialises an MSB-first bit stream and locks byte alignment on COM.
// Once locked, packs data bytes into 32-bit words with a one-cycle valid strobe.
module phy_rx_lane #(
  parameter logic [7:0]  COM       = 8'hBC,
  parameter logic [7:0]  IDLE      = 8'h7C,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active_out,
  output logic        frame_err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] COM_TARGET = CNT_W'(COM_COUNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       sr;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] com_cnt;
  logic [1:0]       byte_idx;
  logic [23:0]      word;

  logic [7:0] win_c;
  logic       byte_done_c;
  logic       ctrl_c;

  // Byte completing on this edge, and whether it ends an aligned byte slot.
  assign win_c       = {sr[6:0], serial_in};
  assign byte_done_c = (bit_cnt == 3'd7);
  assign ctrl_c      = (win_c == COM) || (win_c == IDLE);

  // Alignment state machine, word packer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SEARCH;
      sr         <= 8'd0;
      bit_cnt    <= 3'd0;
      com_cnt    <= '0;
      byte_idx   <= 2'd0;
      word       <= 24'd0;
      data_out   <= 32'd0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sr        <= win_c;
      bit_cnt   <= bit_cnt + 3'd1;
      valid_out <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        SEARCH: begin
          // Any bit offset may start alignment; the boundary is fixed here.
          if (win_c == COM) begin
            bit_cnt <= 3'd0;
            com_cnt <= CNT_W'(1);
            if (COM_TARGET == CNT_W'(1)) begin
              state      <= ACTIVE;
              active_out <= 1'b1;
              byte_idx   <= 2'd0;
            end else begin
              state <= ALIGN;
            end
          end
        end

        ALIGN: begin
          if (byte_done_c) begin
            if (win_c == COM) begin
              com_cnt <= com_cnt + CNT_W'(1);
              if ((com_cnt + CNT_W'(1)) == COM_TARGET) begin
                state      <= ACTIVE;
                active_out <= 1'b1;
                byte_idx   <= 2'd0;
              end
            end else begin
              com_cnt <= '0;
              state   <= SEARCH;
            end
          end
        end

        ACTIVE: begin
          // Sticky until reset; control symbols only matter mid-word.
          if (byte_done_c) begin
            if (ctrl_c) begin
              if (byte_idx != 2'd0) begin
                byte_idx  <= 2'd0;
                word      <= 24'd0;
                frame_err <= 1'b1;
              end
            end else if (byte_idx == 2'd3) begin
              data_out  <= {word, win_c};
              valid_out <= 1'b1;
              byte_idx  <= 2'd0;
              word      <= 24'd0;
            end else begin
              case (byte_idx)
                2'd0:    word[23:16] <= win_c;
                2'd1:    word[15:8]  <= win_c;
                default: word[7:0]   <= win_c;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_rx_lane.sv
// Directed bench for phy_rx_lane: alignment, word packing, framing errors, reset.
module tb_phy_rx_lane;

  logic        clk;
  logic        reset;
  logic        serial_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active_out;
  logic        frame_err;

  int n_checks;
  int n_fail;
  int cyc;
  int fe_cnt;
  int both_cnt;
  logic [31:0] vq[$];
  int          vt[$];

  phy_rx_lane dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active_out (active_out),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for strobe spacing.
  always @(posedge clk) cyc = cyc + 1;

  // Record every strobe seen while out of reset.
  always @(negedge clk) begin
    if (reset) begin
      if (valid_out) begin
        vq.push_back(data_out);
        vt.push_back(cyc);
      end
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (valid_out && frame_err) both_cnt = both_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    serial_in = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Wait for the edge that samples the bit just driven, then settle.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_data"},   data_out, 32'd0);
    check_val({tag, "_valid"},  {31'd0, valid_out}, 32'd0);
    check_val({tag, "_active"}, {31'd0, active_out}, 32'd0);
    check_val({tag, "_ferr"},   {31'd0, frame_err}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_coms(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hBC);
  endtask

  initial begin
    int base;
    int fe_base;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    fe_cnt    = 0;
    both_cnt  = 0;
    reset     = 1'b0;
    serial_in = 1'b0;

    // Reset held 3 cycles with toggling input.
    for (int i = 0; i < 3; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    #1;
    check_idle_outputs("in_reset");
    @(negedge clk);
    reset     = 1'b1;
    serial_in = 1'b0;
    for (int i = 0; i < 64; i++) send_bit(1'b0);
    #1;
    check_idle_outputs("quiet_after_reset");
    check_val("quiet_no_valid", 32'(vq.size()), 32'd0);

    // Junk bits, 4 COMs, one word.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_coms(3);
    after_edge();
    check_val("active_after_3com", {31'd0, active_out}, 32'd0);
    send_byte(8'hBC);
    after_edge();
    check_val("active_after_4com", {31'd0, active_out}, 32'd1);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    after_edge();
    check_val("deadbeef_valid", {31'd0, valid_out}, 32'd1);
    check_val("deadbeef_data", data_out, 32'hDEADBEEF);
    send_bit(1'b0);
    send_bit(1'b0);
    #1;
    check_val("deadbeef_one_pulse", 32'(vq.size()), 32'd1);
    check_val("deadbeef_hold", data_out, 32'hDEADBEEF);

    // Broken COM run restarts the count.
    pulse_reset();
    send_coms(3);
    send_byte(8'h55);
    after_edge();
    check_val("active_after_55", {31'd0, active_out}, 32'd0);
    send_coms(3);
    after_edge();
    check_val("active_after_relock3", {31'd0, active_out}, 32'd0);
    send_byte(8'hBC);
    after_edge();
    check_val("active_after_relock4", {31'd0, active_out}, 32'd1);

    // Control symbols between whole words are ignored.
    base    = vq.size();
    fe_base = fe_cnt;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    after_edge();
    check_val("w1_valid", {31'd0, valid_out}, 32'd1);
    check_val("w1_data", data_out, 32'h11223344);
    send_byte(8'h7C); send_byte(8'hBC);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    after_edge();
    check_val("w2_valid", {31'd0, valid_out}, 32'd1);
    check_val("w2_data", data_out, 32'hA1B2C3D4);
    send_bit(1'b0);
    #1;
    check_val("ctrl_two_pulses", 32'(vq.size() - base), 32'd2);
    check_val("ctrl_no_ferr", 32'(fe_cnt - fe_base), 32'd0);

    // IDLE mid-word drops the partial word; then back-to-back words.
    // Realign the one-bit gap above with a fresh lock.
    pulse_reset();
    send_coms(4);
    base    = vq.size();
    fe_base = fe_cnt;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h7C);
    after_edge();
    check_val("ferr_strobe", {31'd0, frame_err}, 32'd1);
    send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
    after_edge();
    check_val("after_ferr_valid", {31'd0, valid_out}, 32'd1);
    check_val("after_ferr_data", data_out, 32'h0A0B0C0D);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    after_edge();
    check_val("b2b_data", data_out, 32'h01020304);
    send_bit(1'b0);
    #1;
    check_val("ferr_count", 32'(fe_cnt - fe_base), 32'd1);
    check_val("b2b_pulses", 32'(vq.size() - base), 32'd2);
    if (vq.size() - base == 2)
      check_val("b2b_spacing", 32'(vt[base+1] - vt[base]), 32'd32);

    // Reset mid-word, then relock and receive one word.
    pulse_reset();
    send_coms(4);
    send_byte(8'h12); send_byte(8'h34);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("midword_reset");
    @(negedge clk);
    reset   = 1'b1;
    base    = vq.size();
    fe_base = fe_cnt;
    send_coms(4);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    after_edge();
    check_val("cafef00d_valid", {31'd0, valid_out}, 32'd1);
    check_val("cafef00d_data", data_out, 32'hCAFEF00D);
    send_bit(1'b0);
    #1;
    check_val("cafef00d_one_pulse", 32'(vq.size() - base), 32'd1);
    check_val("cafef00d_no_ferr", 32'(fe_cnt - fe_base), 32'd0);
    check_val("never_valid_and_ferr", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
